// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters: arbitrate, latch operands, drive ALU, return result.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [DATA_W-1:0] a_0,
  input  logic [DATA_W-1:0] a_1,
  input  logic [DATA_W-1:0] rd2_0,
  input  logic [DATA_W-1:0] rd2_1,
  input  logic [DATA_W-1:0] imm_0,
  input  logic [DATA_W-1:0] imm_1,
  input  logic              src_0,
  input  logic              src_1,
  input  logic [CTRL_W-1:0] ctl_0,
  input  logic [CTRL_W-1:0] ctl_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rsp_v_0,
  output logic              rsp_v_1,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              port_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [CTRL_W-1:0] ctl_q;
  logic              zero_q;
  logic              idle, pick_1, grant;

  assign idle = (state_q == S_IDLE);

`ifdef ALU_ARB_RR_EN
  logic rr_q;
  assign pick_1 = req_1 & (~req_0 | rr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr_q <= 1'b0;
    else if (grant) rr_q <= ~pick_1;
  end
`else
  assign pick_1 = req_1 & ~req_0;
`endif

  // Grant is gated by rst_n so outputs read zero throughout reset even with req held.
  assign gnt_1 = idle & rst_n & pick_1;
  assign gnt_0 = idle & rst_n & req_0 & ~pick_1;
  assign grant = gnt_0 | gnt_1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      port_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        port_q <= pick_1;
        a_q    <= pick_1 ? a_1 : a_0;
        b_q    <= pick_1 ? (src_1 ? imm_1 : rd2_1) : (src_0 ? imm_0 : rd2_0);
        ctl_q  <= pick_1 ? ctl_1 : ctl_0;
      end
      if (state_q == S_EXEC) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctl  = ctl_q;
  assign rsp_data = res_q;
  assign rsp_zero = zero_q;
  assign rsp_v_0  = (state_q == S_RESP) & ~port_q;
  assign rsp_v_1  = (state_q == S_RESP) &  port_q;

endmodule
